// File: rtl/mem_bus_arbiter_if.sv
// Request/grant/valid bundle shared by the prefetch port, the data port and the arbiter.
// The arbiter uses the slave view. The requesters and the memory use the master view.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_lock;
  logic        d_gnt;
  logic        d_valid;
  logic        flush;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  // mem_rdata runs straight from memory to the requesters; the arbiter only qualifies it.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_lock, flush,
    output if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_lock, flush, mem_rdata,
    input  if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter: data has priority over prefetch, RMW bus lock, prefetch flush.
// Define ARB_STARVE_GUARD_EN to give prefetch one grant after three back-to-back data grants.
module mem_bus_arbiter (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IFETCH, OWN_DREAD, OWN_DWRITE} owner_e;
  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  owner_e r_owner, w_owner_nxt;
  lock_e  r_lock,  w_lock_nxt;
  logic   w_if_gnt, w_d_gnt, w_force_if;

`ifdef ARB_STARVE_GUARD_EN
  logic [1:0] r_starve_cnt, w_starve_cnt_nxt;

  assign w_force_if = (r_starve_cnt == 2'd3) && (r_lock == UNLOCKED) &&
                      bus.d_req && bus.if_req && !bus.flush;

  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (!bus.if_req || w_if_gnt)
      w_starve_cnt_nxt = 2'd0;
    else if (w_d_gnt && (r_starve_cnt != 2'd3))
      w_starve_cnt_nxt = r_starve_cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_starve_cnt <= 2'd0;
    else     r_starve_cnt <= w_starve_cnt_nxt;
  end
`else
  assign w_force_if = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_d_gnt     = 1'b0;
    w_if_gnt    = 1'b0;
    w_owner_nxt = OWN_NONE;
    w_lock_nxt  = r_lock;

    if (!rst) begin
      w_d_gnt  = bus.d_req && !w_force_if;
      w_if_gnt = bus.if_req && !bus.flush && (r_lock == UNLOCKED) && !w_d_gnt;
    end

    if (w_d_gnt)
      w_owner_nxt = bus.d_we ? OWN_DWRITE : OWN_DREAD;
    else if (w_if_gnt)
      w_owner_nxt = OWN_IFETCH;

    if (r_lock == UNLOCKED) begin
      if (w_d_gnt && bus.d_lock) w_lock_nxt = LOCKED;
    end else begin
      if (!bus.d_lock) w_lock_nxt = UNLOCKED;
    end
  end

  always_comb begin
    bus.if_gnt    = w_if_gnt;
    bus.d_gnt     = w_d_gnt;
    bus.mem_en    = w_if_gnt | w_d_gnt;
    bus.mem_we    = w_d_gnt & bus.d_we;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 8'h00;
    if (w_d_gnt) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (w_if_gnt) begin
      bus.mem_addr  = bus.if_addr;
    end
    // A flush in the return cycle discards the prefetch byte. Data returns are never dropped.
    bus.if_valid = !rst && (r_owner == OWN_IFETCH) && !bus.flush;
    bus.d_valid  = !rst && (r_owner == OWN_DREAD);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples the values from before the edge.
    if (rst) begin
      r_owner <= OWN_NONE;
      r_lock  <= UNLOCKED;
    end else begin
      r_owner <= w_owner_nxt;
      r_lock  <= w_lock_nxt;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against a reference model.
// The model tracks the last grant, whether the data port holds the bus, and the data-win streak.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();
  mem_bus_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum {G_NONE, G_IF, G_DR, G_DW} grant_t;

  int     vectors = 0;
  int     miscompares = 0;
  grant_t m_prev = G_NONE;
  bit     m_held = 1'b0;
  int     m_streak = 0;

  // Decide which port the specification's rules pick for the inputs now on the bus.
  function automatic grant_t arbitrate();
    bit if_ok;
    bit force_if;
    if_ok    = bus.if_req && !bus.flush && !m_held;
    force_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    force_if = if_ok && bus.d_req && (m_streak >= 3);
`endif
    if (rst) return G_NONE;
    if (bus.d_req && !force_if) return bus.d_we ? G_DW : G_DR;
    if (if_ok) return G_IF;
    return G_NONE;
  endfunction

  function automatic logic [29:0] pack(logic ig, dg, iv, dv, en, we, logic [15:0] a, logic [7:0] w);
    return {ig, dg, iv, dv, en, we, a, w};
  endfunction

  function automatic logic [29:0] observed_bus();
    return {bus.if_gnt, bus.d_gnt, bus.if_valid, bus.d_valid,
            bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
  endfunction

  function automatic logic [29:0] expected_bus();
    grant_t      g;
    logic        dg, ig;
    logic [15:0] a;
    logic [7:0]  w;
    g  = arbitrate();
    dg = (g == G_DR) || (g == G_DW);
    ig = (g == G_IF);
    a  = dg ? bus.d_addr : (ig ? bus.if_addr : 16'h0000);
    w  = dg ? bus.d_wdata : 8'h00;
    return pack(ig, dg, !rst && (m_prev == G_IF) && !bus.flush, !rst && (m_prev == G_DR),
                dg | ig, g == G_DW, a, w);
  endfunction

  // Advance the model by one clock edge, using the inputs that are now applied, then move to the next negedge.
  task automatic next_cycle();
    grant_t g;
    g = arbitrate();
    if (rst) begin
      m_prev = G_NONE; m_held = 1'b0; m_streak = 0;
    end else begin
      m_prev = g;
      if ((g == G_DR || g == G_DW) && bus.d_lock) m_held = 1'b1;
      else if (!bus.d_lock)                       m_held = 1'b0;
      if (!bus.if_req || g == G_IF)        m_streak = 0;
      else if (g == G_DR || g == G_DW)     m_streak++;
    end
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rst = 1'b0; bus.if_req = 1'b0; bus.if_addr = 16'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 16'h0; bus.d_wdata = 8'h0; bus.d_lock = 1'b0; bus.flush = 1'b0; bus.mem_rdata = 8'h0;
    #1;
    next_cycle();
  endtask

  task automatic test_reset();
    logic [29:0] exp;
    rst = 1'b1; bus.d_req = 1'b1; bus.d_addr = 16'h0010; bus.if_req = 1'b1; bus.if_addr = 16'h0200;
    for (int i = 0; i < 2; i++) begin
      #1; exp = '0;
      vectors++; if (observed_bus() !== exp) begin miscompares++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, observed_bus(), exp); end
      next_cycle();
    end
    rst = 1'b0; #1;
    exp = pack(0, 1, 0, 0, 1, 0, 16'h0010, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL reset_first_grant: got %h want %h", observed_bus(), exp); end
    next_cycle();
    rst = 1'b1; #1; exp = '0;
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL reset_over_read: got %h want %h", observed_bus(), exp); end
    next_cycle();
    rst = 1'b0; bus.d_req = 1'b0; bus.if_req = 1'b0; #1; exp = '0;
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL reset_no_stale_valid: got %h want %h", observed_bus(), exp); end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [29:0] exp;
    drive_idle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0200; bus.d_req = 1'b1; bus.d_addr = 16'h0010; #1;
    exp = pack(0, 1, 0, 0, 1, 0, 16'h0010, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL contention_data_first: got %h want %h", observed_bus(), exp); end
    next_cycle();
    bus.d_req = 1'b0; #1;
    exp = pack(1, 0, 0, 1, 1, 0, 16'h0200, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL contention_prefetch_next: got %h want %h", observed_bus(), exp); end
    next_cycle();
    bus.if_req = 1'b0; #1;
    exp = pack(0, 0, 1, 0, 0, 0, 16'h0000, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL contention_if_valid: got %h want %h", observed_bus(), exp); end
    next_cycle();
  endtask

  task automatic test_write();
    logic [29:0] exp;
    drive_idle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h01FF; bus.d_wdata = 8'hA5; #1;
    exp = pack(0, 1, 0, 0, 1, 1, 16'h01FF, 8'hA5);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL write_strobe: got %h want %h", observed_bus(), exp); end
    next_cycle();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = 8'h00; #1; exp = '0;
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL write_no_valid: got %h want %h", observed_bus(), exp); end
    next_cycle();
  endtask

  task automatic test_flush();
    logic [29:0] exp;
    drive_idle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0300; #1;
    exp = pack(1, 0, 0, 0, 1, 0, 16'h0300, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL flush_first_fetch: got %h want %h", observed_bus(), exp); end
    next_cycle();
    bus.if_addr = 16'h0301; bus.flush = 1'b1; #1; exp = '0;
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL flush_kills_valid_and_gnt: got %h want %h", observed_bus(), exp); end
    next_cycle();
    bus.flush = 1'b0; #1;
    exp = pack(1, 0, 0, 0, 1, 0, 16'h0301, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL flush_refetch: got %h want %h", observed_bus(), exp); end
    next_cycle();
    bus.if_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 16'h0020; bus.flush = 1'b1; #1;
    exp = pack(0, 1, 0, 0, 1, 0, 16'h0020, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL flush_with_data: got %h want %h", observed_bus(), exp); end
    next_cycle();
    bus.d_req = 1'b0; #1;
    exp = pack(0, 0, 0, 1, 0, 0, 16'h0000, 8'h00);
    vectors++; if (observed_bus() !== exp) begin miscompares++;
      $display("FAIL flush_keeps_d_valid: got %h want %h", observed_bus(), exp); end
    next_cycle();
  endtask

  task automatic test_lock();
    logic [29:0] exp [5];
    exp[0] = pack(0, 1, 0, 0, 1, 0, 16'h0040, 8'h00);
    exp[1] = pack(0, 0, 0, 1, 0, 0, 16'h0000, 8'h00);
    exp[2] = pack(0, 1, 0, 0, 1, 1, 16'h0040, 8'h5A);
    exp[3] = '0;
    exp[4] = pack(1, 0, 0, 0, 1, 0, 16'h0300, 8'h00);
    drive_idle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0300; bus.d_addr = 16'h0040;
    for (int i = 0; i < 5; i++) begin
      bus.d_req   = (i == 0 || i == 2);
      bus.d_we    = (i == 2);
      bus.d_wdata = (i == 2) ? 8'h5A : 8'h00;
      bus.d_lock  = (i < 3);
      #1;
      vectors++; if (observed_bus() !== exp[i]) begin miscompares++;
        $display("FAIL lock_step%0d: got %h want %h", i, observed_bus(), exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    drive_idle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0400; bus.d_req = 1'b1; bus.d_addr = 16'h0080;
    for (int i = 0; i < 8; i++) begin
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp = ((i % 4) == 3) ? 2'b10 : 2'b01;
`else
      exp = 2'b01;
`endif
      vectors++; if ({bus.if_gnt, bus.d_gnt} !== exp) begin miscompares++;
        $display("FAIL starve_pattern[%0d]: got if/d=%b want %b", i, {bus.if_gnt, bus.d_gnt}, exp); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [29:0] exp;
    grant_t      g;
    bit          if_pend, d_pend;
    drive_idle();
    if_pend = 1'b0; d_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!if_pend) begin
        if_pend = ($urandom_range(0, 9) < 6);
        bus.if_addr = 16'($urandom);
      end
      if (!d_pend) begin
        d_pend = ($urandom_range(0, 9) < 5);
        bus.d_we = 1'($urandom); bus.d_addr = 16'($urandom); bus.d_wdata = 8'($urandom);
      end
      bus.if_req = if_pend;
      bus.d_req  = d_pend;
      bus.d_lock = m_held ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      bus.flush  = ($urandom_range(0, 7) == 0);
      bus.mem_rdata = 8'($urandom);
      #1;
      exp = expected_bus();
      g   = arbitrate();
      vectors++; if (observed_bus() !== exp) begin miscompares++;
        $display("FAIL random[%0d]: got %h want %h", i, observed_bus(), exp); end
      if (g == G_IF) if_pend = 1'b0;
      if (g == G_DR || g == G_DW) d_pend = 1'b0;
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; bus.if_req = 1'b0; bus.if_addr = 16'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 16'h0; bus.d_wdata = 8'h0; bus.d_lock = 1'b0; bus.flush = 1'b0; bus.mem_rdata = 8'h0;
    @(negedge clk);
    test_reset();
    test_contention();
    test_write();
    test_flush();
    test_lock();
    test_starvation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 clk  in  1  core clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-003 if_req  in  1  instruction prefetch requests one byte read.
REQ-004 if_addr  in  16  prefetch byte address.
REQ-005 if_gnt  out  1  prefetch request accepted this cycle.
REQ-006 if_valid  out  1  prefetch read data valid on mem_rdata.
REQ-007 d_req  in  1  data/operand access request.
REQ-008 d_we  in  1  1 = write, 0 = read.
REQ-009 d_addr  in  16  data address.
REQ-010 d_wdata  in  8  write data.
REQ-011 d_lock  in  1  hold bus for data port (read-modify-write sequences).
REQ-012 d_gnt  out  1  data request accepted this cycle.
REQ-013 d_valid  out  1  data read data valid on mem_rdata (never for writes).
REQ-014 flush  in  1  taken branch or interrupt; discard outstanding prefetch.
REQ-015 mem_en  out  1  memory access strobe.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  16  memory address.
REQ-018 mem_wdata  out  8  memory write data.
REQ-019 mem_rdata  in  8  memory read data, valid exactly 1 cycle after mem_en with mem_we=0.

Function
REQ-020 Single shared port; at most one grant per cycle; if_gnt and d_gnt SHALL never be high together.
REQ-021 Grant is combinational from registered state and current requests; mem_en = if_gnt | d_gnt; mem_addr/mem_we/mem_wdata SHALL come from the granted port (mem_we=0, mem_wdata=0 when prefetch granted, all zero when idle).
REQ-022 Read latency: d_valid / if_valid SHALL assert exactly 1 cycle after the matching grant for reads; back-to-back grants every cycle SHALL be supported.
REQ-023 Owner register: NONE, IFETCH, DREAD, DWRITE; records the port granted in the previous cycle and selects which valid to raise.
REQ-024 Default priority: data over prefetch.
REQ-025 Lock state machine: UNLOCKED -> LOCKED when d_gnt and d_lock both high; LOCKED -> UNLOCKED on the first cycle d_lock is low; while LOCKED, if_gnt SHALL be 0 regardless of other inputs.
REQ-026 flush in cycle N SHALL suppress if_valid in cycle N (owner IFETCH) and SHALL block if_gnt in cycle N; d_valid is unaffected.
REQ-027 flush and d_req in the same cycle: data granted normally.
REQ-028 Requesters hold req/addr until granted; arbiter holds no request queue.

Reset
REQ-029 While rst high: if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we = 0; mem_addr, mem_wdata = 0; owner = NONE; lock = UNLOCKED; starvation counter = 0.
REQ-030 A read granted in the cycle rst asserts SHALL NOT produce a valid after reset.
REQ-031 First grant is possible in the first cycle after rst deasserts.

Configuration
REQ-032 Macro ARB_STARVE_GUARD_EN: when defined, a 2-bit counter counts consecutive d_gnt cycles while if_req is pending; when it reaches 3 and LOCKED is not set, the next contended cycle SHALL grant prefetch and clear the counter; counter clears on any if_gnt or when if_req is low.
REQ-033 Without ARB_STARVE_GUARD_EN: strict data priority; prefetch may starve indefinitely; counter absent.

Verification
REQ-034 Reset: assert rst with d_req=1, if_req=1 -> all outputs 0 during reset; d_gnt=1 in first cycle after release.
REQ-035 Contention: if_req=1 @0x0200, d_req=1 read @0x0010 -> d_gnt, mem_addr=0x0010; next cycle d_valid=1, if_gnt=1, mem_addr=0x0200; next cycle if_valid=1.
REQ-036 Write: d_we=1, d_addr=0x01FF, d_wdata=0xA5 -> mem_en=1, mem_we=1, mem_wdata=0xA5; no d_valid next cycle.
REQ-037 Flush: if_gnt @0x0300 in cycle N, flush=1 in N+1 -> if_valid=0 in N+1, if_gnt=0 in N+1.
REQ-038 Lock: RMW @0x0040 read with d_lock=1, then write, d_lock low after write; if_req held high throughout -> if_gnt=0 until the cycle after d_lock falls.
REQ-039 Starvation (ARB_STARVE_GUARD_EN defined): d_req and if_req held high continuously -> grant pattern D,D,D,I repeating; undefined -> all D.
